// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared ISA field constants, exception codes and multdiv FSM state type
package cpu_pkg;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SETX  = 5'b10101;
    localparam logic [4:0] OP_BEX   = 5'b10110;

    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    localparam logic [2:0] EXC_MUL  = 3'd4;
    localparam logic [2:0] EXC_DIV  = 3'd5;

    // bex tests rstatus, which lives in r30
    localparam logic [4:0] REG_RSTATUS = 5'd30;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    function automatic logic [4:0] insn_opcode(input logic [31:0] insn);
        return insn[31:27];
    endfunction

    function automatic logic [4:0] insn_rd(input logic [31:0] insn);
        return insn[26:22];
    endfunction

    function automatic logic [4:0] insn_rs(input logic [31:0] insn);
        return insn[21:17];
    endfunction

    function automatic logic [4:0] insn_rt(input logic [31:0] insn);
        return insn[16:12];
    endfunction

    function automatic logic [4:0] insn_alu(input logic [31:0] insn);
        return insn[6:2];
    endfunction

endpackage

// File: rtl/source_decode.sv
// rtl/source_decode.sv - extracts the source registers an instruction reads, plus lw/mul/div flags
module source_decode
    import cpu_pkg::*;
(
    input  logic [31:0] insn_i,
    output logic [4:0]  src1_o,
    output logic        src1_use_o,
    output logic [4:0]  src2_o,
    output logic        src2_use_o,
    output logic        is_lw_o,
    output logic        is_mul_o,
    output logic        is_div_o
);

    logic [4:0] opcode;
    logic [4:0] alu_op;
    logic       unused_bits;

    assign opcode      = insn_opcode(insn_i);
    assign alu_op      = insn_alu(insn_i);
    assign unused_bits = ^{insn_i[11:7], insn_i[1:0]};

    always_comb begin
        src1_o     = 5'd0;
        src1_use_o = 1'b0;
        src2_o     = 5'd0;
        src2_use_o = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                src1_o     = insn_rs(insn_i);
                src1_use_o = 1'b1;
                src2_o     = insn_rt(insn_i);
                src2_use_o = 1'b1;
            end
            // sw data register is forwarded MW->XM, so only the base counts
            OP_ADDI, OP_LW, OP_SW: begin
                src1_o     = insn_rs(insn_i);
                src1_use_o = 1'b1;
            end
            OP_BNE, OP_BLT: begin
                src1_o     = insn_rd(insn_i);
                src1_use_o = 1'b1;
                src2_o     = insn_rs(insn_i);
                src2_use_o = 1'b1;
            end
            OP_JR: begin
                src1_o     = insn_rd(insn_i);
                src1_use_o = 1'b1;
            end
            OP_BEX: begin
                src1_o     = REG_RSTATUS;
                src1_use_o = 1'b1;
            end
            default: begin
                src1_use_o = 1'b0;
                src2_use_o = 1'b0;
            end
        endcase
    end

    assign is_lw_o  = (opcode == OP_LW);
    assign is_mul_o = (opcode == OP_RTYPE) && (alu_op == ALU_MUL);
    assign is_div_o = (opcode == OP_RTYPE) && (alu_op == ALU_DIV);

endmodule

// File: rtl/stall_control.sv
// rtl/stall_control.sv - pipeline interlock: load-use bubbles and multi-cycle mul/div sequencing
module stall_control
    import cpu_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      FDinsn,
    input  logic [31:0]      DXinsn,
    input  logic             branch_flush,
    input  logic             multdiv_ready,
    input  logic             multdiv_exception,
    output logic             stall_front,
    output logic             bubble_DX,
    output logic             bubble_XM,
    output logic             ctrl_MULT,
    output logic             ctrl_DIV,
    output logic             md_capture,
    output logic             md_exc_valid,
    output logic [2:0]       md_exc_code,
    output logic [CNT_W-1:0] stall_cycles
);

    md_state_e        state_q, state_d;
    logic             op_is_div_q, op_is_div_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    logic [4:0] fd_src1, fd_src2, dx_src1, dx_src2;
    logic       fd_use1, fd_use2, dx_use1, dx_use2;
    logic       fd_is_lw, fd_is_mul, fd_is_div;
    logic       dx_is_lw, dx_is_mul, dx_is_div;
    logic [4:0] dx_rd;
    logic       load_use;
    logic       unused_decode;

    source_decode u_fd_decode (
        .insn_i     (FDinsn),
        .src1_o     (fd_src1),
        .src1_use_o (fd_use1),
        .src2_o     (fd_src2),
        .src2_use_o (fd_use2),
        .is_lw_o    (fd_is_lw),
        .is_mul_o   (fd_is_mul),
        .is_div_o   (fd_is_div)
    );

    source_decode u_dx_decode (
        .insn_i     (DXinsn),
        .src1_o     (dx_src1),
        .src1_use_o (dx_use1),
        .src2_o     (dx_src2),
        .src2_use_o (dx_use2),
        .is_lw_o    (dx_is_lw),
        .is_mul_o   (dx_is_mul),
        .is_div_o   (dx_is_div)
    );

    // FD's own class flags and DX's sources play no part in the interlock
    assign unused_decode = ^{fd_is_lw, fd_is_mul, fd_is_div,
                             dx_src1, dx_use1, dx_src2, dx_use2};

    assign dx_rd    = insn_rd(DXinsn);
    assign load_use = dx_is_lw && (dx_rd != 5'd0) && !branch_flush &&
                      ((fd_use1 && (fd_src1 == dx_rd)) ||
                       (fd_use2 && (fd_src2 == dx_rd)));

    always_comb begin
        state_d      = state_q;
        op_is_div_d  = op_is_div_q;
        stall_front  = 1'b0;
        bubble_DX    = 1'b0;
        bubble_XM    = 1'b0;
        ctrl_MULT    = 1'b0;
        ctrl_DIV     = 1'b0;
        md_capture   = 1'b0;
        md_exc_valid = 1'b0;
        md_exc_code  = 3'd0;
        if (!reset) begin
            case (state_q)
                MD_IDLE: begin
                    if ((dx_is_mul || dx_is_div) && !branch_flush) begin
                        ctrl_MULT   = dx_is_mul;
                        ctrl_DIV    = dx_is_div;
                        op_is_div_d = dx_is_div;
                        stall_front = 1'b1;
                        bubble_XM   = 1'b1;
                        state_d     = MD_BUSY;
                    end else if (load_use) begin
                        stall_front = 1'b1;
                        bubble_DX   = 1'b1;
                    end
                end
                MD_BUSY: begin
                    if (multdiv_ready) begin
                        md_capture   = 1'b1;
                        md_exc_valid = multdiv_exception;
                        md_exc_code  = op_is_div_q ? EXC_DIV : EXC_MUL;
                        state_d      = MD_IDLE;
                    end else begin
                        stall_front = 1'b1;
                        bubble_XM   = 1'b1;
                    end
                end
                default: state_d = MD_IDLE;
            endcase
        end
    end

    assign stall_cycles_d = stall_cycles_q + CNT_W'(stall_front);
    assign stall_cycles   = reset ? '0 : stall_cycles_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= MD_IDLE;
            op_is_div_q    <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            op_is_div_q    <= op_is_div_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

endmodule

// File: tb/tb_stall_control.sv
// tb/tb_stall_control.sv - scoreboard bench for stall_control with a behavioural interlock model
module tb_stall_control;

    localparam int CNT_W = 4;

    localparam logic [4:0] LW = 5'b01000, SW = 5'b00111, RT = 5'b00000;

    logic              clock;
    logic              reset;
    logic [31:0]       FDinsn, DXinsn;
    logic              branch_flush, multdiv_ready, multdiv_exception;
    logic              stall_front, bubble_DX, bubble_XM, ctrl_MULT, ctrl_DIV;
    logic              md_capture, md_exc_valid;
    logic [2:0]        md_exc_code;
    logic [CNT_W-1:0]  stall_cycles;

    stall_control #(.CNT_W(CNT_W)) dut (
        .clock             (clock),
        .reset             (reset),
        .FDinsn            (FDinsn),
        .DXinsn            (DXinsn),
        .branch_flush      (branch_flush),
        .multdiv_ready     (multdiv_ready),
        .multdiv_exception (multdiv_exception),
        .stall_front       (stall_front),
        .bubble_DX         (bubble_DX),
        .bubble_XM         (bubble_XM),
        .ctrl_MULT         (ctrl_MULT),
        .ctrl_DIV          (ctrl_DIV),
        .md_capture        (md_capture),
        .md_exc_valid      (md_exc_valid),
        .md_exc_code       (md_exc_code),
        .stall_cycles      (stall_cycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic       stall;
        logic       bdx;
        logic       bxm;
        logic       mult;
        logic       div;
        logic       cap;
        logic       excv;
        logic [2:0] code;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // reference state: is a multdiv operation outstanding, which kind, stalls so far
    bit m_busy = 0;
    bit m_div  = 0;
    int m_cnt  = 0;

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] alu);
        return {op, rd, rs, rt, 5'd0, alu, 2'b00};
    endfunction

    // set of registers an FD instruction reads for interlock purposes
    function automatic logic [31:0] read_set(input logic [31:0] insn);
        logic [31:0] s = '0;
        case (insn[31:27])
            5'b00000:                   begin s[insn[21:17]] = 1'b1; s[insn[16:12]] = 1'b1; end
            5'b00101, 5'b01000, 5'b00111: s[insn[21:17]] = 1'b1;
            5'b00010, 5'b00110:          begin s[insn[26:22]] = 1'b1; s[insn[21:17]] = 1'b1; end
            5'b00100:                    s[insn[26:22]] = 1'b1;
            5'b10110:                    s[30] = 1'b1;
            default:                     s = '0;
        endcase
        return s;
    endfunction

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
        end
    endtask

    // one clock of stimulus: drive, predict, push, then advance the model
    task automatic step(input logic rst, input logic [31:0] fd, input logic [31:0] dx,
                        input logic fl, input logic rdy, input logic exc);
        exp_t e;
        bit   is_md, dx_div;
        reset = rst; FDinsn = fd; DXinsn = dx;
        branch_flush = fl; multdiv_ready = rdy; multdiv_exception = exc;
        e = '0;
        is_md  = (dx[31:27] == 5'd0) && (dx[6:2] == 5'd6 || dx[6:2] == 5'd7);
        dx_div = (dx[6:2] == 5'd7);
        if (!rst) begin
            e.cnt = CNT_W'(m_cnt % (1 << CNT_W));
            if (!m_busy) begin
                if (is_md && !fl) begin
                    e.mult = !dx_div; e.div = dx_div; e.stall = 1; e.bxm = 1;
                end else if (dx[31:27] == 5'b01000 && dx[26:22] != 0 && !fl &&
                             read_set(fd)[dx[26:22]]) begin
                    e.stall = 1; e.bdx = 1;
                end
            end else if (!rdy) begin
                e.stall = 1; e.bxm = 1;
            end else begin
                e.cap = 1; e.excv = exc; e.code = m_div ? 3'd5 : 3'd4;
            end
        end
        exp_q.push_back(e);
        if (rst) begin
            m_busy = 0; m_div = 0; m_cnt = 0;
        end else begin
            if (e.stall) m_cnt++;
            if (e.mult || e.div) begin m_busy = 1; m_div = dx_div; end
            else if (e.cap) m_busy = 0;
        end
        @(posedge clock); #1;
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("stall_front",  stall_front,  e.stall);
            check("bubble_DX",    bubble_DX,    e.bdx);
            check("bubble_XM",    bubble_XM,    e.bxm);
            check("ctrl_MULT",    ctrl_MULT,    e.mult);
            check("ctrl_DIV",     ctrl_DIV,     e.div);
            check("md_capture",   md_capture,   e.cap);
            check("md_exc_valid", md_exc_valid, e.excv);
            check("md_exc_code",  md_exc_code,  e.code);
            check("stall_cycles", stall_cycles, e.cnt);
        end
    end

    function automatic logic [31:0] rand_insn();
        logic [4:0] ops [11] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
                                 5'b00110, 5'b00111, 5'b01000, 5'b10101, 5'b10110};
        logic [4:0] alus [4] = '{5'd0, 5'd1, 5'd6, 5'd7};
        logic [4:0] op, rd, rs, rt;
        op = ops[$urandom_range(0, 10)];
        rd = ($urandom_range(0, 15) == 0) ? 5'd30 : 5'($urandom_range(0, 3));
        rs = 5'($urandom_range(0, 3));
        rt = 5'($urandom_range(0, 3));
        return mk(op, rd, rs, rt, alus[$urandom_range(0, 3)]);
    endfunction

    initial begin
        logic [31:0] nop, lw5, add6, sw5, lw0, add0, mul, dv;
        nop  = 32'd0;
        lw5  = mk(LW, 5'd5, 5'd2, 5'd0, 5'd0);
        add6 = mk(RT, 5'd6, 5'd5, 5'd1, 5'd0);
        sw5  = mk(SW, 5'd5, 5'd3, 5'd0, 5'd0);
        lw0  = mk(LW, 5'd0, 5'd2, 5'd0, 5'd0);
        add0 = mk(RT, 5'd6, 5'd0, 5'd1, 5'd0);
        mul  = mk(RT, 5'd7, 5'd1, 5'd2, 5'd6);
        dv   = mk(RT, 5'd8, 5'd1, 5'd2, 5'd7);
        reset = 1; FDinsn = 0; DXinsn = 0;
        branch_flush = 0; multdiv_ready = 0; multdiv_exception = 0;
        @(posedge clock); #1;
        step(1, nop, nop, 0, 0, 0);
        step(1, add6, lw5, 0, 1, 1);
        // load-use, then the dependent instruction behind a bubble
        step(0, add6, lw5, 0, 0, 0);
        step(0, add6, nop, 0, 0, 0);
        step(0, sw5, lw5, 0, 0, 0);
        step(0, add0, lw0, 0, 0, 0);
        step(0, add6, lw5, 1, 0, 0);
        // multiply with ready three cycles after the start pulse
        step(0, add6, mul, 0, 0, 0);
        step(0, add6, mul, 0, 0, 0);
        step(0, add6, mul, 0, 0, 0);
        step(0, add6, mul, 0, 1, 0);
        step(0, nop, nop, 0, 0, 0);
        // divide with exception
        step(0, nop, dv, 0, 0, 0);
        step(0, nop, dv, 0, 0, 0);
        step(0, nop, dv, 0, 1, 1);
        // back-to-back multiplies, then a stray ready in IDLE
        step(0, mul, mul, 0, 0, 0);
        step(0, mul, mul, 0, 1, 0);
        step(0, nop, mul, 0, 0, 0);
        step(0, nop, mul, 0, 1, 0);
        step(0, nop, nop, 0, 1, 1);
        // reset in the middle of a divide; the late ready must be ignored
        step(0, nop, dv, 0, 0, 0);
        step(0, nop, dv, 0, 0, 0);
        step(1, nop, dv, 0, 0, 0);
        step(0, nop, nop, 0, 1, 1);
        step(0, nop, nop, 0, 0, 0);
        // randomized traffic; the 4-bit counter wraps several times
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 149) == 0), rand_insn(), rand_insn(),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
        if (exp_q.size() > 0) begin
            bad++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
